servo_pwm_bank: RTL and testbench
=================================

# servo_pwm_bank

Three-channel hobby-servo PWM back end that consumes the per-channel pulse-length commands (microseconds, nominal 1500) produced by the gait/sequencer top level and drives the three servo control pins. Each channel holds a frame-synchronous, double-buffered pulse width. New commands are clamped to a safe range and slew-limited per frame, so a step command can never produce a torn or out-of-range pulse. The block sits directly downstream of the sequencer, next to the servo enable pins.

## Interface
Parameters:
- CLK_PER_US, 50: clocks per microsecond (50 MHz CLK).
- FRAME_US, 20000: PWM frame length in µs.
- PW_MIN, 500: lower clamp in µs; must be ≥1.
- PW_MAX, 2500: upper clamp in µs; must be < FRAME_US.
- PW_RESET, 1500: width applied on reset.
- MAX_STEP, 0: maximum change of the active width per frame in µs; 0 disables slew limiting.

Ports:
- CLK  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- pul_len1 / pul_len2 / pul_len3  in  16 each  commanded pulse widths in µs, unsigned.
- load  in  1  single-cycle strobe; samples all three pul_len inputs into the pending registers.
- CTL_PIN1 / CTL_PIN2 / CTL_PIN3  out  1 each  servo PWM outputs, registered.
- frame_start  out  1  one-cycle pulse marking the first cycle of each frame.
- pending  out  1  high from a load until the frame start that consumes it.
- clamp_flag  out  1  one-cycle pulse at frame start if any consumed command was clamped.

## Operation
- Microsecond prescaler us_cnt counts 0..CLK_PER_US-1. Tick is asserted when us_cnt = CLK_PER_US-1.
- Frame counter frame_us advances on tick over 0..FRAME_US-1. The tick at FRAME_US-1 wraps it to 0 and registers frame_start = 1 for the next cycle.
- Load: on load, pend_n <= pul_len_n and pending <= 1. Several loads in one frame: the last one wins.
- Frame update happens on the edge where frame_us wraps. Per channel:
  - target_n <= clamp(pend_n) if pending, otherwise target_n is unchanged.
  - If MAX_STEP = 0, active_n <= the new target.
  - Otherwise active_n moves toward the new target by min(|target−active|, MAX_STEP).
  - pending clears on this edge unless load is asserted in the same cycle. In that case the new values are pending for the next frame, and the current update uses the old pend values.
- Clamp: value < PW_MIN gives PW_MIN; value > PW_MAX gives PW_MAX. clamp_flag pulses alongside frame_start if any channel was clamped.
- Output: CTL_PIN_n <= (frame_us < active_n), where active_n is the value in effect for the current frame.
- Arithmetic:
  - 16-bit unsigned throughout.
  - Slew compare is done at 17 bits to avoid wrap.
  - frame_us is 16 bits (FRAME_US ≤ 65535).

## Timing
- Reset values:
  - CTL_PIN1..3 = 0, frame_start = 0, pending = 0, clamp_flag = 0.
  - us_cnt = 0, frame_us = 0.
  - active/target/pend = PW_RESET.
- The first frame starts on the first edge after rst deasserts. CTL_PINs rise on that edge with PW_RESET widths. No frame_start pulse is issued for this first frame.
- High time per channel = active_n × CLK_PER_US clocks exactly. Frame period = FRAME_US × CLK_PER_US clocks.
- Command latency: a load is visible at the next frame boundary, 1 to FRAME_US×CLK_PER_US clocks later. A mid-frame load never alters the pulse in progress.
- Rising edges of all channels coincide with frame_start.
- Reset mid-pulse: outputs drop low asynchronously and all state returns to reset values. Pending commands are discarded.

## Structure
- Package servo_pkg holds:
  - The default constants: CLK_PER_US, FRAME_US, PW_MIN, PW_MAX, PW_RESET.
  - The pulse-width typedef (16-bit unsigned).
  - A clamp function.
- Sub-module servo_pwm_ch, instantiated 3×. It contains pend/target/active, clamp, slew and the output compare, and is driven by the shared frame_us, the wrap strobe and load.
- The prescaler, frame counter, pending, frame_start and clamp_flag logic live in the top of servo_pwm_bank.

## Test plan
- Reset/default: release rst → every frame each CTL_PIN is high 75000 clocks, low 925000 clocks; frame_start period = 1000000 clocks.
- Load 1000/1500/2000 mid-frame → current frame keeps 75000 on all channels; next frame gives 50000/75000/100000 clocks high; pending clears at that frame_start.
- Clamp: load 100/3000/1500 → next frame gives 25000/125000/75000 clocks high; clamp_flag pulses once, coincident with frame_start.
- Slew: MAX_STEP=8, active 1500, load 1600 → successive frames 1508, 1516 … 1596, 1600 µs; 13 frames to settle.
- Load coincident with wrap: load 1200 on the wrap edge while pend = 1800 → this frame uses 1800; next frame 1200; pending stays high across the boundary.
- Reset mid-pulse: assert rst at frame_us = 700 with active 2000 → CTL_PINs low immediately; after release widths = 1500 and pending = 0.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared defaults, pulse-width type and clamp helper for the servo PWM bank.
package servo_pkg;

  localparam int DEF_CLK_PER_US = 50;
  localparam int DEF_FRAME_US   = 20000;
  localparam int DEF_PW_MIN     = 500;
  localparam int DEF_PW_MAX     = 2500;
  localparam int DEF_PW_RESET   = 1500;

  typedef logic [15:0] pw_t;

  function automatic pw_t clamp_pw(input pw_t v, input pw_t lo, input pw_t hi);
    pw_t r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo channel: pending command, clamp, per-frame slew and pulse compare.
// Output is registered; commands take effect only on the frame wrap strobe.
module servo_pwm_ch
  import servo_pkg::*;
#(
  parameter int PW_MIN   = DEF_PW_MIN,
  parameter int PW_MAX   = DEF_PW_MAX,
  parameter int PW_RESET = DEF_PW_RESET,
  parameter int MAX_STEP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] frame_us,
  input  logic        wrap,
  input  logic        load,
  input  logic        pending,
  input  logic [15:0] pul_len,
  output logic        pin,
  output logic        clamped
);

  localparam pw_t        LO     = 16'(PW_MIN);
  localparam pw_t        HI     = 16'(PW_MAX);
  localparam pw_t        RST_PW = 16'(PW_RESET);
  localparam pw_t        STEP16 = 16'(MAX_STEP);
  localparam logic [16:0] STEP17 = 17'(MAX_STEP);

  pw_t pend;
  pw_t target;
  pw_t active;
  pw_t next_target;
  pw_t next_active;

  always_comb begin
    clamped     = (pend < LO) || (pend > HI);
    next_target = pending ? clamp_pw(pend, LO, HI) : target;
    next_active = next_target;
    // Compare at 17 bits so active +/- step can never wrap around 16 bits.
    if (MAX_STEP != 0) begin
      if ({1'b0, next_target} > ({1'b0, active} + STEP17)) begin
        next_active = active + STEP16;
      end else if ({1'b0, active} > ({1'b0, next_target} + STEP17)) begin
        next_active = active - STEP16;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= RST_PW;
      target <= RST_PW;
      active <= RST_PW;
      pin    <= 1'b0;
    end else begin
      if (load) pend <= pul_len;
      if (wrap) begin
        target <= next_target;
        active <= next_active;
      end
      pin <= (frame_us < active);
    end
  end

endmodule

// File: rtl/servo_pwm_bank.sv
// Three-channel servo PWM: shared microsecond prescaler and frame counter, per-channel pulse units.
// Pins and status are registered; commands are consumed at the frame boundary, no backpressure.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int CLK_PER_US = DEF_CLK_PER_US,
  parameter int FRAME_US   = DEF_FRAME_US,
  parameter int PW_MIN     = DEF_PW_MIN,
  parameter int PW_MAX     = DEF_PW_MAX,
  parameter int PW_RESET   = DEF_PW_RESET,
  parameter int MAX_STEP   = 0
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [15:0] pul_len1,
  input  logic [15:0] pul_len2,
  input  logic [15:0] pul_len3,
  input  logic        load,
  output logic        CTL_PIN1,
  output logic        CTL_PIN2,
  output logic        CTL_PIN3,
  output logic        frame_start,
  output logic        pending,
  output logic        clamp_flag
);

  localparam int             USW        = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [USW-1:0] US_LAST    = USW'(CLK_PER_US - 1);
  localparam pw_t            FRAME_LAST = 16'(FRAME_US - 1);

  logic [USW-1:0] us_cnt;
  pw_t            frame_us;
  logic           tick;
  logic           wrap;
  logic           wrapped;
  logic           clamp_hit;
  logic [2:0]     pins;
  logic [2:0]     clamped;
  logic [15:0]    cmd [3];

  assign tick   = (us_cnt == US_LAST);
  assign wrap   = tick && (frame_us == FRAME_LAST);
  assign cmd[0] = pul_len1;
  assign cmd[1] = pul_len2;
  assign cmd[2] = pul_len3;

  // Pins compare against frame_us one cycle late, so the frame markers are
  // delayed by one cycle as well to line up with the rising pin edges.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      us_cnt      <= '0;
      frame_us    <= '0;
      pending     <= 1'b0;
      wrapped     <= 1'b0;
      clamp_hit   <= 1'b0;
      frame_start <= 1'b0;
      clamp_flag  <= 1'b0;
    end else begin
      us_cnt <= tick ? '0 : us_cnt + 1'b1;
      if (tick) frame_us <= (frame_us == FRAME_LAST) ? '0 : frame_us + 16'd1;
      if (load)      pending <= 1'b1;
      else if (wrap) pending <= 1'b0;
      wrapped     <= wrap;
      clamp_hit   <= wrap && pending && (|clamped);
      frame_start <= wrapped;
      clamp_flag  <= clamp_hit;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    servo_pwm_ch #(
      .PW_MIN  (PW_MIN),
      .PW_MAX  (PW_MAX),
      .PW_RESET(PW_RESET),
      .MAX_STEP(MAX_STEP)
    ) u_ch (
      .clk     (CLK),
      .rst     (rst),
      .frame_us(frame_us),
      .wrap    (wrap),
      .load    (load),
      .pending (pending),
      .pul_len (cmd[i]),
      .pin     (pins[i]),
      .clamped (clamped[i])
    );
  end

  assign CTL_PIN1 = pins[0];
  assign CTL_PIN2 = pins[1];
  assign CTL_PIN3 = pins[2];

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: one unslewed and one slew-limited instance share the command inputs.
module tb_servo_pwm_bank;

  localparam int CPU   = 2;
  localparam int FUS   = 200;
  localparam int FCYC  = CPU * FUS;
  localparam int NROWS = 22;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        load = 1'b0;
  logic [15:0] pl1  = '0;
  logic [15:0] pl2  = '0;
  logic [15:0] pl3  = '0;
  logic [2:0]  pin_a, pin_b;
  logic        fs_a, fs_b, pd_a, pd_b, cf_a, cf_b;

  int tests  = 0;
  int fails  = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  servo_pwm_bank #(.CLK_PER_US(CPU), .FRAME_US(FUS), .PW_MIN(20), .PW_MAX(150),
                   .PW_RESET(60), .MAX_STEP(0)) dut_a (
    .CLK(clk), .rst(rst), .pul_len1(pl1), .pul_len2(pl2), .pul_len3(pl3), .load(load),
    .CTL_PIN1(pin_a[0]), .CTL_PIN2(pin_a[1]), .CTL_PIN3(pin_a[2]),
    .frame_start(fs_a), .pending(pd_a), .clamp_flag(cf_a));

  servo_pwm_bank #(.CLK_PER_US(CPU), .FRAME_US(FUS), .PW_MIN(20), .PW_MAX(150),
                   .PW_RESET(60), .MAX_STEP(8)) dut_b (
    .CLK(clk), .rst(rst), .pul_len1(pl1), .pul_len2(pl2), .pul_len3(pl3), .load(load),
    .CTL_PIN1(pin_b[0]), .CTL_PIN2(pin_b[1]), .CTL_PIN3(pin_b[2]),
    .frame_start(fs_b), .pending(pd_b), .clamp_flag(cf_b));

  // One frame: up to two loads (offset -1 = none), expected widths in us for
  // both instances, and clamp_flag/pending as seen at the following frame start.
  typedef struct {
    int o1, v11, v12, v13;
    int o2, v21, v22, v23;
    int a1, a2, a3;
    int cf, pd;
    int b1, b2, b3;
  } row_t;

  row_t rows [NROWS];
  row_t exp_q [$];
  int   idx_q [$];

  function automatic row_t mk(int o1, int v11, int v12, int v13, int o2, int v21, int v22, int v23,
                              int a1, int a2, int a3, int cf, int pd, int b1, int b2, int b3);
    row_t r;
    r.o1 = o1; r.v11 = v11; r.v12 = v12; r.v13 = v13;
    r.o2 = o2; r.v21 = v21; r.v22 = v22; r.v23 = v23;
    r.a1 = a1; r.a2 = a2; r.a3 = a3; r.cf = cf; r.pd = pd;
    r.b1 = b1; r.b2 = b2; r.b3 = b3;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, got, want);
    end
  endtask

  // Monitor: accumulates high cycles per frame and checks them against the queue.
  initial begin : monitor
    int cnt_a [3];
    int cnt_b [3];
    int period;
    bit seen;
    logic [2:0] prev_a, prev_b;
    row_t e;
    int id;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        for (int c = 0; c < 3; c++) begin
          cnt_a[c] = 0;
          cnt_b[c] = 0;
        end
        period = 0;
        seen   = 1'b0;
        prev_a = '0;
        prev_b = '0;
      end else begin
        if (cf_a && !fs_a) check("clamp_flag_outside_frame_start", 0, 1, 0);
        if (fs_a) begin
          check("frame_start_aligned_b", 0, int'(fs_b), 1);
          if (seen) check("frame_period", 0, period, FCYC);
          if (exp_q.size() == 0) begin
            check("expectation_available", 0, 0, 1);
          end else begin
            e  = exp_q.pop_front();
            id = idx_q.pop_front();
            check("width_a1", id, cnt_a[0], e.a1 * CPU);
            check("width_a2", id, cnt_a[1], e.a2 * CPU);
            check("width_a3", id, cnt_a[2], e.a3 * CPU);
            check("width_b1", id, cnt_b[0], e.b1 * CPU);
            check("width_b2", id, cnt_b[1], e.b2 * CPU);
            check("width_b3", id, cnt_b[2], e.b3 * CPU);
            check("clamp_flag", id, int'(cf_a), e.cf);
            check("pending_after_wrap", id, int'(pd_a), e.pd);
          end
          seen   = 1'b1;
          period = 0;
          for (int c = 0; c < 3; c++) begin
            cnt_a[c] = 0;
            cnt_b[c] = 0;
          end
        end
        for (int c = 0; c < 3; c++) begin
          if (seen && pin_a[c] && !prev_a[c]) check("rise_a_on_frame_start", c, int'(fs_a), 1);
          if (seen && pin_b[c] && !prev_b[c]) check("rise_b_on_frame_start", c, int'(fs_b), 1);
          cnt_a[c] += int'(pin_a[c]);
          cnt_b[c] += int'(pin_b[c]);
        end
        period++;
        prev_a = pin_a;
        prev_b = pin_b;
      end
    end
  end

  // pos counts negedges since the frame's first (frame_start) negedge.
  task automatic pulse_load(inout int pos, input int off, input int v1, input int v2, input int v3);
    while (pos < off) begin
      @(negedge clk);
      pos++;
    end
    pl1  = 16'(v1);
    pl2  = 16'(v2);
    pl3  = 16'(v3);
    load = 1'b1;
    @(negedge clk);
    pos++;
    load = 1'b0;
  endtask

  task automatic run_frame(input int id);
    row_t r;
    int   pos;
    bit   got;
    r   = rows[id];
    pos = 0;
    got = 1'b0;
    exp_q.push_back(r);
    idx_q.push_back(id);
    if (r.o1 >= 0) pulse_load(pos, r.o1, r.v11, r.v12, r.v13);
    if (r.o2 >= 0) pulse_load(pos, r.o2, r.v21, r.v22, r.v23);
    for (int c = 0; c < FCYC + 8; c++) begin
      @(negedge clk);
      if (fs_a) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("frame_start_timeout", id, 0, 1);
  endtask

  initial begin : driver
    int pos;
    rows[0]  = mk(-1,  0,  0,  0,  -1,  0,  0,  0,   60,  60,  60, 0, 0,  60, 60, 60);
    rows[1]  = mk(50, 40, 60, 80,  -1,  0,  0,  0,   60,  60,  60, 0, 0,  60, 60, 60);
    rows[2]  = mk(-1,  0,  0,  0,  -1,  0,  0,  0,   40,  60,  80, 0, 0,  52, 60, 68);
    rows[3]  = mk(10, 10,170,100,  -1,  0,  0,  0,   40,  60,  80, 1, 0,  44, 60, 76);
    rows[4]  = mk(20,140,140,140, 300,120, 90, 30,   20, 150, 100, 0, 0,  36, 68, 84);
    rows[5]  = mk(40, 90, 90, 90, FCYC-2, 70, 71, 72, 120, 90, 30, 0, 1,  44, 76, 76);
    rows[6]  = mk(-1,  0,  0,  0,  -1,  0,  0,  0,   90,  90,  90, 0, 0,  52, 84, 84);
    rows[7]  = mk(-1,  0,  0,  0,  -1,  0,  0,  0,   70,  71,  72, 0, 0,  60, 76, 76);
    rows[8]  = mk( 5, 20,150, 19,  -1,  0,  0,  0,   70,  71,  72, 1, 0,  68, 71, 72);
    rows[9]  = mk( 5, 20,150,151,  -1,  0,  0,  0,   20, 150,  20, 1, 0,  60, 79, 64);
    rows[10] = mk( 5, 60, 60, 60,  -1,  0,  0,  0,   20, 150, 150, 0, 0,  52, 87, 72);
    rows[11] = mk(-1,  0,  0,  0,  -1,  0,  0,  0,   60,  60,  60, 0, 0,  60, 79, 64);
    rows[12] = mk(-1,  0,  0,  0,  -1,  0,  0,  0,   60,  60,  60, 0, 0,  60, 71, 60);
    rows[13] = mk(-1,  0,  0,  0,  -1,  0,  0,  0,   60,  60,  60, 0, 0,  60, 63, 60);
    rows[14] = mk( 5, 97, 60, 20,  -1,  0,  0,  0,   60,  60,  60, 0, 0,  60, 60, 60);
    rows[15] = mk(-1,  0,  0,  0,  -1,  0,  0,  0,   97,  60,  20, 0, 0,  68, 60, 52);
    rows[16] = mk(-1,  0,  0,  0,  -1,  0,  0,  0,   97,  60,  20, 0, 0,  76, 60, 44);
    rows[17] = mk(-1,  0,  0,  0,  -1,  0,  0,  0,   97,  60,  20, 0, 0,  84, 60, 36);
    rows[18] = mk(-1,  0,  0,  0,  -1,  0,  0,  0,   97,  60,  20, 0, 0,  92, 60, 28);
    rows[19] = mk(-1,  0,  0,  0,  -1,  0,  0,  0,   97,  60,  20, 0, 0,  97, 60, 20);
    rows[20] = mk( 5,150,150,150,  -1,  0,  0,  0,   97,  60,  20, 0, 0,  97, 60, 20);
    rows[21] = mk(-1,  0,  0,  0,  -1,  0,  0,  0,   60,  60,  60, 0, 0,  60, 60, 60);

    repeat (3) @(negedge clk);
    check("reset_pins_a", 0, int'(pin_a), 0);
    check("reset_pins_b", 0, int'(pin_b), 0);
    check("reset_frame_start", 0, int'(fs_a), 0);
    check("reset_pending", 0, int'(pd_a), 0);
    check("reset_clamp_flag", 0, int'(cf_a), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= 20; i++) run_frame(i);

    // Reset in the middle of a 150 us pulse with a command still pending.
    mon_en = 1'b0;
    pos    = 0;
    pulse_load(pos, 5, 40, 40, 40);
    check("pending_after_load", 0, int'(pd_a), 1);
    while (pos < 200) begin
      @(negedge clk);
      pos++;
    end
    check("pins_high_mid_pulse", 0, int'(pin_a), 7);
    rst = 1'b1;
    #1;
    check("pins_a_low_in_reset", 0, int'(pin_a), 0);
    check("pins_b_low_in_reset", 0, int'(pin_b), 0);
    check("pending_cleared_by_reset", 0, int'(pd_a), 0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("pending_after_release", 0, int'(pd_a), 0);
    run_frame(21);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
